// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit and its prefetch buffer.
package ifu_pkg;

  localparam int XLEN_DEF    = 64;
  localparam int ILEN_DEF    = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic {
    S_RUN,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_prefetch_sync_fifo.sv
// Small synchronous FIFO with clear; push on a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit with in-order prefetch buffer and redirect drain.
// Optional IFU_PREFETCH_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              ILEN     = ILEN_DEF,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            req_valid,
  output logic [XLEN-1:0] req_addr,
  input  logic            req_ready,
  input  logic            rsp_valid,
  input  logic [ILEN-1:0] rsp_instr,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  input  logic            out_ready,
  output logic            busy
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = XLEN + ILEN;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] redirect_aligned;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   inflight_nxt;
  logic [CW:0]     occupancy;
  logic            req_fire;
  logic            rsp_ok;
  logic            rsp_live;
  logic            bypass_hit;
  logic            bypass_take;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [EW-1:0]   fifo_wdata;
  logic [EW-1:0]   fifo_rdata;

  assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
  assign occupancy        = {1'b0, fifo_count} + {1'b0, inflight};
  assign req_addr         = fetch_pc;
  assign req_fire         = req_valid & req_ready;
  assign rsp_ok           = rsp_valid & (inflight != '0);
  assign inflight_nxt     = inflight + CW'(req_fire) - CW'(rsp_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  // A redirect only needs to drain if requests are still outstanding after this cycle.
  always_comb begin
    state_nxt = state;
    if (redirect_valid)
      state_nxt = (inflight_nxt != '0) ? S_DRAIN : S_RUN;
    else if (state == S_DRAIN && inflight_nxt == '0)
      state_nxt = S_RUN;
  end

  // Requests are credit-limited so every outstanding fetch has a buffer slot waiting.
  always_comb begin
    req_valid = 1'b0;
    rsp_live  = 1'b0;
    if (state == S_RUN) begin
      req_valid = ~rst & (occupancy < DEPTH_W);
      rsp_live  = rsp_ok & ~redirect_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
        resp_pc  <= redirect_aligned;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
        if (rsp_live) resp_pc  <= resp_pc + XLEN'(INSTR_BYTES);
      end
    end
  end

`ifdef IFU_PREFETCH_BYPASS_EN
  assign bypass_hit = fifo_empty & rsp_live;
`else
  assign bypass_hit = 1'b0;
`endif

  assign bypass_take = bypass_hit & out_ready;
  assign fifo_push   = rsp_live & ~bypass_take;
  assign fifo_pop    = out_valid & out_ready;
  assign fifo_wdata  = {resp_pc, rsp_instr};

  sync_fifo #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .clear(redirect_valid),
    .push (fifo_push),
    .wdata(fifo_wdata),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Outputs read as zero whenever nothing valid is presented.
  always_comb begin
    out_valid = ~fifo_empty | bypass_hit;
    out_pc    = '0;
    out_instr = '0;
    if (!fifo_empty) begin
      out_pc    = fifo_rdata[EW-1:ILEN];
      out_instr = fifo_rdata[ILEN-1:0];
    end else if (bypass_hit) begin
      out_pc    = resp_pc;
      out_instr = rsp_instr;
    end
  end

  assign busy = (inflight != '0) | ~fifo_empty;

`ifndef SYNTHESIS
  rsp_without_request: assert property (@(posedge clk) disable iff (rst)
    !(rsp_valid && inflight == '0));
  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full && !fifo_pop));
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomised and directed self-checking bench for ifu_prefetch against a queue-based fetch model.
module tb_ifu_prefetch;
  import ifu_pkg::*;

  localparam int          XLEN     = 64;
  localparam int          ILEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            req_valid;
  logic [XLEN-1:0] req_addr;
  logic            req_ready;
  logic            rsp_valid;
  logic [ILEN-1:0] rsp_instr;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_instr;
  logic            out_ready;
  logic            busy;

  ifu_prefetch #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_instr(rsp_instr),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Each outstanding fetch remembers its address, when memory may answer, and whether a redirect orphaned it.
  typedef struct {
    logic [63:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  pend_t        memQ[$];
  fetch_entry_t bufQ[$];
  logic [63:0]  nextFetch;
  int           cycleNo;
  int           memLat;
  int           passCount;
  int           checkCount;
  int           failCount;

  function automatic logic [31:0] instrOf(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_req_valid", req_valid, 0);
    checkOutput("rst_req_addr", req_addr, RESET_PC);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_pc", out_pc, 0);
    checkOutput("rst_out_instr", out_instr, 0);
    checkOutput("rst_busy", busy, 0);
  endtask

  // One clock cycle: drive, check against the model, advance the model, cross the edge.
  task automatic applyStimulus(input bit outRdy, input bit reqRdy, input bit redir, input logic [63:0] rpc);
    bit           rspV;
    bit           rspStale;
    logic [31:0]  rspI;
    bit           draining;
    bit           expReq;
    bit           bypassOut;
    bit           expOutValid;
    fetch_entry_t expHead;
    pend_t        p;

    rspV     = (memQ.size() > 0) && (memQ[0].due <= cycleNo);
    rspStale = rspV && memQ[0].stale;
    rspI     = rspV ? instrOf(memQ[0].addr) : $urandom;
    out_ready      = outRdy;
    req_ready      = reqRdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    rsp_valid      = rspV;
    rsp_instr      = rspI;
    #2;

    draining  = (memQ.size() > 0) && memQ[0].stale;
    expReq    = !draining && (bufQ.size() + memQ.size() < DEPTH);
    bypassOut = 1'b0;
`ifdef IFU_PREFETCH_BYPASS_EN
    bypassOut = (bufQ.size() == 0) && rspV && !rspStale && !redir;
`endif
    expOutValid = (bufQ.size() > 0) || bypassOut;
    expHead     = '0;
    if (bufQ.size() > 0) expHead = bufQ[0];
    else if (bypassOut) begin
      expHead.pc    = memQ[0].addr;
      expHead.instr = rspI;
    end

    checkOutput("req_valid", req_valid, expReq);
    if (expReq) checkOutput("req_addr", req_addr, nextFetch);
    checkOutput("out_valid", out_valid, expOutValid);
    if (expOutValid) begin
      checkOutput("out_pc", out_pc, expHead.pc);
      checkOutput("out_instr", out_instr, expHead.instr);
    end
    checkOutput("busy", busy, (memQ.size() != 0) || (bufQ.size() != 0));

    if (expOutValid && outRdy && bufQ.size() > 0) void'(bufQ.pop_front());
    if (rspV) begin
      p = memQ.pop_front();
      if (!p.stale && !redir && !(bypassOut && outRdy)) begin
        expHead.pc    = p.addr;
        expHead.instr = rspI;
        bufQ.push_back(expHead);
      end
    end
    if (expReq && reqRdy) begin
      p.addr  = nextFetch;
      p.due   = cycleNo + memLat;
      p.stale = 1'b0;
      memQ.push_back(p);
      nextFetch = nextFetch + 64'd4;
    end
    if (redir) begin
      bufQ.delete();
      foreach (memQ[i]) memQ[i].stale = 1'b1;
      nextFetch = {rpc[63:2], 2'b00};
    end

    @(posedge clk);
    #1;
    cycleNo++;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int waited;
    bit reached;
    passCount = 0; checkCount = 0; failCount = 0;
    cycleNo = 0; memLat = 1; nextFetch = RESET_PC;
    rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_instr = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkReset();
    rst = 1'b0;

    // Streaming fetch from a one-cycle memory.
    repeat (12) applyStimulus(1, 1, 0, '0);

    // Decode stalls: credits run out at DEPTH, then fetch resumes.
    repeat (10) applyStimulus(0, 1, 0, '0);
    checkOutput("stall_req_valid", req_valid, 0);
    checkOutput("stall_busy", busy, 1);
    repeat (8) applyStimulus(1, 1, 0, '0);

    // Redirect with three fetches in flight.
    memLat  = 3;
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      applyStimulus(1, 1, 0, '0);
      reached = (memQ.size() == 3);
    end
    checkOutput("three_inflight_reached", reached, 1);
    applyStimulus(1, 0, 1, 64'h8000_1003);
    waited = 0;
    while (!req_valid && waited < 10) begin
      applyStimulus(1, 1, 0, '0);
      waited++;
    end
    checkOutput("redir_req_seen", req_valid, 1);
    checkOutput("redir_req_addr", req_addr, 64'h8000_1000);
    repeat (10) applyStimulus(1, 1, 0, '0);

    // Redirect coinciding with a request handshake and a response.
    memLat = 1;
    repeat (6) applyStimulus(1, 1, 0, '0);
    applyStimulus(1, 1, 1, 64'h8000_2000);
    repeat (8) applyStimulus(1, 1, 0, '0);

    // Fetch PC wraps past the top of the address space.
    applyStimulus(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    waited = 0;
    while (!req_valid && waited < 10) begin
      applyStimulus(1, 0, 0, '0);
      waited++;
    end
    checkOutput("wrap_req_addr0", req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1, 1, 0, '0);
    checkOutput("wrap_req_addr1", req_addr, 64'h0);
    repeat (6) applyStimulus(1, 1, 0, '0);

    // Random traffic with varying latency, backpressure and redirects.
    for (int i = 0; i < 400; i++) begin
      logic [63:0] rpc;
      if (i % 50 == 0) memLat = $urandom_range(1, DEPTH - 1);
      rpc = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                        : {32'($urandom), 32'($urandom)};
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 24) == 0, rpc);
    end

    // Reset in the middle of traffic.
    rst = 1'b1;
    redirect_valid = 1'b0; rsp_valid = 1'b0; req_ready = 1'b0; out_ready = 1'b0;
    #2;
    checkReset();
    memQ.delete();
    bufQ.delete();
    nextFetch = RESET_PC;
    @(posedge clk);
    #1;
    rst = 1'b0;
    memLat = 2;
    repeat (20) applyStimulus(1, 1, 0, '0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
